// File: rtl/puerto_salida_fifo.sv
// Memory-mapped output port: CPU stores into a 4-word address window are queued
// as {port, data} entries and presented to a consumer over a valid/ready handshake.
module puerto_salida_fifo #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic [15:0]                direcciones,
  input  logic [15:0]                datos,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                out_data,
  output logic [1:0]                 out_port,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [17:0]   storage [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          overflow_q;

  logic hit;
  logic push;
  logic pop;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign out_valid = !empty;
  assign count     = count_q;
  assign overflow  = overflow_q;

  assign hit  = we && (direcciones[15:2] == BASE_ADDR[15:2]);
  assign pop  = out_valid && out_ready;
  // A pop frees a slot on the same edge, so a full FIFO can still accept.
  assign push = hit && (!full || pop);

  assign out_data = empty ? 16'h0000 : storage[rd_ptr][15:0];
  assign out_port = empty ? 2'b00    : storage[rd_ptr][17:16];

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      storage[wr_ptr] <= {direcciones[1:0], datos};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
      if (hit && !push) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule
